// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for a RAM with a combinational read port.
// It drives the RAM read address and captures the read data. It then streams a
// window of words out over a valid/ready handshake.
// Optional feature macro: RAM_STREAM_READER_REPEAT_EN. When it is defined, the
// window is replayed reps+1 times. When it is undefined, each start gives one pass.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int REP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] base_addr,
    input  logic [DEPTH_LOG2:0]   length,
    input  logic [REP_WIDTH-1:0]  reps,
    input  logic                  abort,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [DEPTH_LOG2-1:0]   ram_addr_reg, ram_addr_next;
    logic [DEPTH_LOG2-1:0]   base_reg, base_next;
    logic [DEPTH_LOG2:0]     length_reg, length_next;
    logic [DEPTH_LOG2:0]     issued_reg, issued_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                    out_valid_reg, out_valid_next;
    logic                    done_reg, done_next;
    logic [DEPTH_LOG2:0]     len_clamped;
    logic [DEPTH_LOG2:0]     issued_inc;
    logic                    more_passes;

`ifdef RAM_STREAM_READER_REPEAT_EN
    logic [REP_WIDTH-1:0]    reps_reg, reps_next;
    logic [REP_WIDTH-1:0]    pass_reg, pass_next;
    assign more_passes = (pass_reg != reps_reg);
`else
    // Without replay, the repeat count has no effect.
    logic unused_reps;
    assign unused_reps = ^reps;
    assign more_passes = 1'b0;
`endif

    // Oversized windows are limited to one full sweep of the RAM.
    assign len_clamped = (length > DEPTH_WORDS) ? DEPTH_WORDS : length;
    assign issued_inc  = issued_reg + 1'b1;

    // Next-state and datapath decisions. Abort wins over every other request.
    always_comb begin
        state_next     = state_reg;
        ram_addr_next  = ram_addr_reg;
        base_next      = base_reg;
        length_next    = length_reg;
        issued_next    = issued_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        done_next      = 1'b0;
`ifdef RAM_STREAM_READER_REPEAT_EN
        reps_next      = reps_reg;
        pass_next      = pass_reg;
`endif
        if (abort) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (len_clamped == '0) begin
                            done_next = 1'b1;
                        end else begin
                            base_next     = base_addr;
                            length_next   = len_clamped;
                            ram_addr_next = base_addr;
                            issued_next   = '0;
`ifdef RAM_STREAM_READER_REPEAT_EN
                            reps_next     = reps;
                            pass_next     = '0;
`endif
                            state_next    = RUN;
                        end
                    end
                end
                RUN: begin
                    if ((!out_valid_reg || out_ready) && (issued_reg < length_reg)) begin
                        out_data_next  = ram_data;
                        out_valid_next = 1'b1;
                        if (issued_inc == length_reg) begin
                            // Last word of a pass. Restart or finish on this
                            // same fetch so no bubble is left between passes.
                            if (more_passes) begin
                                ram_addr_next = base_reg;
                                issued_next   = '0;
`ifdef RAM_STREAM_READER_REPEAT_EN
                                pass_next     = pass_reg + 1'b1;
`endif
                            end else begin
                                ram_addr_next = ram_addr_reg + 1'b1;
                                issued_next   = issued_inc;
                                state_next    = DRAIN;
                            end
                        end else begin
                            ram_addr_next = ram_addr_reg + 1'b1;
                            issued_next   = issued_inc;
                        end
                    end else begin
                        if (out_valid_reg && out_ready) begin
                            out_valid_next = 1'b0;
                        end
                        if (issued_reg >= length_reg) begin
                            state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_reg || out_ready) begin
                        out_valid_next = 1'b0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ram_addr_reg  <= '0;
            base_reg      <= '0;
            length_reg    <= '0;
            issued_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
`ifdef RAM_STREAM_READER_REPEAT_EN
            reps_reg      <= '0;
            pass_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ram_addr_reg  <= ram_addr_next;
            base_reg      <= base_next;
            length_reg    <= length_next;
            issued_reg    <= issued_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
`ifdef RAM_STREAM_READER_REPEAT_EN
            reps_reg      <= reps_next;
            pass_reg      <= pass_next;
`endif
        end
    end

    assign ram_addr  = ram_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader.
// Expected words are queued when a start is driven and popped on each handshake.
module tb_ram_stream_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] length = '0;
    logic [7:0] reps = '0;
    logic       abort = 1'b0;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    assign ram_data = mem[ram_addr];

    ram_stream_reader #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .REP_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .reps(reps), .abort(abort), .ram_addr(ram_addr),
        .ram_data(ram_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Drives a one-cycle start. When the start should be accepted, it also
    // queues the expected words.
    task automatic start_xfer(input logic [3:0] b, input logic [4:0] l,
                              input logic [7:0] r, input bit accept);
        int n;
        int passes;
        n = (l > 5'd16) ? 16 : int'(l);
        passes = 1;
`ifdef RAM_STREAM_READER_REPEAT_EN
        passes = int'(r) + 1;
`endif
        if (accept)
            for (int p = 0; p < passes; p++)
                for (int i = 0; i < n; i++)
                    exp_q.push_back(mem[(int'(b) + i) % 16]);
        base_addr = b; length = l; reps = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("start base=%0d length=%0d reps=%0d queued=%0d", b, l, r, exp_q.size());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ram_addr !== 4'd0) begin bad++; $display("FAIL reset_ram_addr got=%0h exp=0", ram_addr); end
        total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        total++; if ({out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, done}); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_basic();
        int hs = 0; int last_hs = -10; int dcyc = -1; int bubbles = 0;
        logic [7:0] e;
        out_ready = 1'b1;
        start_xfer(4'd2, 5'd4, 8'd0, 1'b1);
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_after_e0 got valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
        for (int c = 0; c < 30 && dcyc < 0; c++) begin
            if (c == 1) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got valid=%b exp=1", out_valid); end
            end
            if (done) begin
                dcyc = c;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_with_done got=%b exp=0", busy); end
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL basic_data got=%h exp=%h", out_data, e); end
                $display("basic word %0d data=%h", hs, out_data);
                hs++; last_hs = c;
            end else if (hs > 0 && hs < 4) bubbles++;
            @(negedge clk);
        end
        total++; if (hs !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", hs); end
        total++; if (dcyc !== last_hs + 1) begin bad++; $display("FAIL basic_done_timing got=%0d exp=%0d", dcyc, last_hs + 1); end
        total++; if (bubbles !== 0) begin bad++; $display("FAIL basic_bubbles got=%0d exp=0", bubbles); end
    endtask

    task automatic test_wrap();
        int hs = 0; int k = 0; bit seen = 0;
        logic [3:0] exp_addr [4];
        logic [7:0] e;
        exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
        out_ready = 1'b1;
        start_xfer(4'd14, 5'd4, 8'd0, 1'b1);
        for (int c = 0; c < 30 && !seen; c++) begin
            if (busy && k < 4) begin
                total++; if (ram_addr !== exp_addr[k]) begin bad++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", k, ram_addr, exp_addr[k]); end
                k++;
            end
            if (done) seen = 1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL wrap_data got=%h exp=%h", out_data, e); end
                $display("wrap word %0d data=%h", hs, out_data);
                hs++;
            end
            @(negedge clk);
        end
        total++; if (hs !== 4 || !seen) begin bad++; $display("FAIL wrap_complete got words=%0d done=%b exp words=4 done=1", hs, seen); end
    endtask

    task automatic test_stall();
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int hs = 0; bit seen = 0; bit held_v = 0;
        logic [7:0] held_d = '0;
        logic [7:0] e;
        out_ready = 1'b1;
        start_xfer(4'd0, 5'd3, 8'd0, 1'b1);
        for (int c = 0; c < 40 && !seen; c++) begin
            if (held_v) begin
                total++; if (out_valid !== 1'b1 || out_data !== held_d) begin bad++; $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, held_d); end
            end
            if (done) seen = 1;
            out_ready = (c < 7) ? pat[c][0] : 1'b1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL stall_data got=%h exp=%h", out_data, e); end
                $display("stall word %0d data=%h", hs, out_data);
                hs++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            @(negedge clk);
        end
        out_ready = 1'b1;
        total++; if (hs !== 3 || !seen || exp_q.size() !== 0) begin bad++; $display("FAIL stall_complete got words=%0d done=%b left=%0d exp 3/1/0", hs, seen, exp_q.size()); end
    endtask

    task automatic test_repeat();
        int hs = 0; int dones = 0; int bubbles = 0; int expn;
        logic [7:0] e;
        out_ready = 1'b1;
        start_xfer(4'd5, 5'd2, 8'd2, 1'b1);
        expn = exp_q.size();
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL repeat_data got=%h exp=%h", out_data, e); end
                $display("repeat word %0d data=%h", hs, out_data);
                hs++;
            end else if (hs > 0 && hs < expn) bubbles++;
            @(negedge clk);
        end
        total++; if (hs !== expn) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", hs, expn); end
        total++; if (dones !== 1) begin bad++; $display("FAIL repeat_done_pulses got=%0d exp=1", dones); end
        total++; if (bubbles !== 0) begin bad++; $display("FAIL repeat_bubbles got=%0d exp=0", bubbles); end
    endtask

    task automatic test_abort();
        int hs = 0; int dones = 0; bit seen = 0;
        logic [7:0] e;
        out_ready = 1'b1;
        start_xfer(4'd0, 5'd6, 8'd0, 1'b1);
        for (int c = 0; c < 20 && hs < 2; c++) begin
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL abort_pre_data got=%h exp=%h", out_data, e); end
                hs++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0; abort = 1'b1;
        start = 1'b1; base_addr = 4'd9; length = 5'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        exp_q.delete();
        total++; if ({out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL abort_next got valid/busy/done=%b exp=000", {out_valid, busy, done}); end
        for (int c = 0; c < 4; c++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", dones); end
        $display("abort after %0d words", hs);
        out_ready = 1'b1;
        hs = 0;
        start_xfer(4'd0, 5'd1, 8'd0, 1'b1);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL abort_restart_data got=%h exp=%h", out_data, e); end
                hs++;
            end
            @(negedge clk);
        end
        total++; if (hs !== 1 || !seen) begin bad++; $display("FAIL abort_restart got words=%0d done=%b exp 1/1", hs, seen); end
    endtask

    task automatic test_zero_length();
        int vcount = 0; int dones = 0;
        out_ready = 1'b1;
        start_xfer(4'd3, 5'd0, 8'd0, 1'b1);
        total++; if ({done, busy, out_valid} !== 3'b100) begin bad++; $display("FAIL zero_done got done/busy/valid=%b exp=100", {done, busy, out_valid}); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
            if (done) dones++;
        end
        total++; if (vcount !== 0 || dones !== 0) begin bad++; $display("FAIL zero_after got valid=%0d done=%0d exp 0/0", vcount, dones); end
    endtask

    task automatic test_back_to_back();
        int hs = 0; bit seen = 0;
        logic [7:0] e;
        out_ready = 1'b1;
        // Length 20 clamps to a full sweep of 16 words starting at 4.
        start_xfer(4'd4, 5'd20, 8'd0, 1'b1);
        for (int c = 0; c < 60 && !seen; c++) begin
            start = (c == 3);
            base_addr = 4'd8; length = 5'd2;
            if (done) seen = 1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (out_data !== e) begin bad++; $display("FAIL busy_start_data got=%h exp=%h", out_data, e); end
                hs++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (hs !== 16 || !seen || exp_q.size() !== 0) begin bad++; $display("FAIL busy_start_complete got words=%0d done=%b left=%0d exp 16/1/0", hs, seen, exp_q.size()); end
        $display("busy start ignored, words=%0d", hs);
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        start_xfer(4'd0, 5'd8, 8'd0, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({ram_addr, out_data, out_valid, busy, done} !== 15'd0) begin bad++; $display("FAIL reset_mid_run got addr=%0d data=%h v/b/d=%b exp all 0", ram_addr, out_data, {out_valid, busy, done}); end
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        $display("reset mid-run checked");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_repeat();
        test_abort();
        test_zero_length();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side sequencer for the team's single-write-port RAM with combinational read.
- Drives the RAM read address, captures read data, and streams a programmed window of words out over a valid/ready handshake.
- Used for waveform/sample playback out of a RAM that is loaded by the write side.
- Optionally replays the window a programmed number of times.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- DEPTH_LOG2, 4, RAM address width; DEPTH = 2^DEPTH_LOG2.
- REP_WIDTH, 8, width of the repeat-count input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only when idle.
- base_addr  input  DEPTH_LOG2  first RAM address of the window; sampled on an accepted start.
- length  input  DEPTH_LOG2+1  words per pass; sampled on start; values above DEPTH are clamped to DEPTH.
- reps  input  REP_WIDTH  extra passes (total passes = reps+1); sampled on start; used only with the optional feature.
- abort  input  1  synchronous cancel of the current transfer.
- ram_addr  output  DEPTH_LOG2  RAM read address.
- ram_data  input  DATA_WIDTH  RAM read data for ram_addr, same cycle (combinational).
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready at posedge.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes normally.

Behaviour:
- Reset values: ram_addr, out_data, out_valid, busy, done = 0. State = IDLE. Internal counters = 0.
- Reset has priority over everything else. After abort, the state is IDLE.

States:
- IDLE
  - busy=0.
  - Accepted start with clamped length!=0: latch base/length/reps, set ram_addr<=base_addr, clear word and pass counters, go to RUN.
  - Accepted start with length==0: done=1 on the next cycle, no data emitted, stay in IDLE.
- RUN
  - busy=1.
  - Fetch condition: (!out_valid || out_ready) && issued<length.
    - out_data<=ram_data, out_valid<=1.
    - ram_addr<=ram_addr+1, wrapping modulo DEPTH.
    - issued<=issued+1.
  - issued==length and another pass remains: ram_addr<=base, issued<=0, pass<=pass+1. This takes no extra bubble: the restart happens in the same cycle the condition is seen, so the next fetch uses base.
  - issued==length and this is the last pass: go to DRAIN.
- DRAIN
  - busy=1.
  - When out_valid && out_ready, or when out_valid==0: out_valid<=0, done<=1, go to IDLE.

Cycle and handshake rules:
- done is a one-cycle pulse; busy=0 in that cycle.
- A start presented in the cycle done is high is accepted.
- Latency: start sampled at edge E0 → first out_valid high after edge E1 (2 edges).
- With out_ready held at 1: one word per cycle, no bubbles, including across pass boundaries.
- out_data and out_valid stay stable while out_valid && !out_ready.
- No word is dropped or duplicated under arbitrary out_ready patterns.

Boundary conditions:
- start while busy: ignored; latched values are unchanged.
- Window wrap: base+length>DEPTH wraps to address 0.
- length==DEPTH: every word is read exactly once per pass.
- abort, any state: next cycle state=IDLE, out_valid=0, busy=0, no done pulse. Same-cycle start is ignored.
- The RAM may be written during a transfer. The reader returns whatever ram_data shows at fetch time; there is no coherency logic.

Optional Feature:
- Macro: RAM_STREAM_READER_REPEAT_EN.
- Defined: reps is honoured; total passes = reps+1; the pass counter is REP_WIDTH bits.
- Undefined: reps is ignored, exactly one pass per start, and no pass counter is synthesized.

Test Plan:
- RAM[0..15]=8'h10..8'h1F; base=2, length=4, out_ready=1, start at E0 → out_valid high after E1; data 12,13,14,15 on consecutive cycles; done pulse the cycle after the 4th handshake; busy low with done.
- base=14, length=4 → data 1E,1F,10,11 (address wrap); ram_addr returns 14→15→0→1.
- base=0, length=3, out_ready toggling 1,0,0,1,0,1,1 → data 10,11,12 each accepted exactly once; out_data held stable during stalls.
- With REPEAT_EN: base=5, length=2, reps=2, out_ready=1 → 15,16,15,16,15,16 back-to-back; single done pulse.
- Abort after 2nd of 6 words → out_valid=0 and busy=0 next cycle; no done pulse. A new start (base=0, length=1) then yields 10 and done.
- length=0 start → done next cycle, out_valid never high. Start while busy (length=16) → ignored; original transfer completes unchanged. Reset mid-RUN → all outputs 0 next cycle.
